// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, the IF/ID pipeline register and the
// RUN/HALTED fetch state machine, plus a saturating count of enabled RUN cycles.
module fetch_stage #(
  parameter int unsigned               NB_ADDR     = 32,
  parameter int unsigned               NB_INSTR    = 32,
  parameter int unsigned               NB_OPCODE   = 6,
  parameter logic [NB_OPCODE-1:0]      HALT_OPCODE = 6'b111111,
  parameter int unsigned               NB_COUNT    = 32
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_enable,
  input  logic                i_hazard,
  input  logic                i_branch_taken,
  input  logic [NB_ADDR-1:0]  i_branch_target,
  input  logic                i_jump,
  input  logic [NB_ADDR-1:0]  i_jump_target,
  output logic [NB_ADDR-1:0]  o_imem_addr,
  input  logic [NB_INSTR-1:0] i_imem_data,
  output logic [NB_INSTR-1:0] o_instr,
  output logic [NB_ADDR-1:0]  o_pc_next,
  output logic                o_valid,
  output logic                o_halt,
  output logic [NB_COUNT-1:0] o_cycle_count
);

  typedef enum logic {RUN, HALTED} state_e;

  state_e              state_q;
  logic [NB_ADDR-1:0]  pc_q, pc_d;
  logic [NB_INSTR-1:0] instr_q, instr_d;
  logic [NB_ADDR-1:0]  pc_next_q, pc_next_d;
  logic                valid_q, valid_d;
  logic [NB_COUNT-1:0] count_q, count_d;

  logic [NB_ADDR-1:0]  pc_plus4;
  logic [NB_ADDR-1:0]  redirect_target;
  logic                redirect;
  logic                is_halt;
  logic                halt_entry;

  assign pc_plus4        = pc_q + NB_ADDR'(4);
  assign redirect        = i_branch_taken | i_jump;
  // The branch comes from the older instruction, so it beats a same-cycle jump.
  assign redirect_target = i_branch_taken ? i_branch_target : i_jump_target;
  assign is_halt         = (i_imem_data[NB_INSTR-1 -: NB_OPCODE] == HALT_OPCODE);
  assign halt_entry      = (state_q == RUN) && !redirect && !i_hazard && is_halt;

  always_comb begin
    // NOTE: every _d gets a hold default first so no path leaves it unassigned (no latches).
    pc_d      = pc_q;
    instr_d   = instr_q;
    pc_next_d = pc_next_q;
    valid_d   = valid_q;
    count_d   = count_q;
    if (i_enable) begin
      if ((state_q == RUN) && (count_q != '1)) count_d = count_q + NB_COUNT'(1);
      if (redirect) begin
        pc_d      = redirect_target;
        instr_d   = '0;
        pc_next_d = '0;
        valid_d   = 1'b0;
      end else if (state_q == HALTED) begin
        instr_d   = '0;
        pc_next_d = '0;
        valid_d   = 1'b0;
      end else if (!i_hazard) begin
        instr_d   = i_imem_data;
        pc_next_d = pc_plus4;
        valid_d   = 1'b1;
        // A fetched HALT keeps the PC parked on itself.
        if (!is_halt) pc_d = pc_plus4;
      end
    end
  end

  // NOTE: reset is sampled on the clock edge and uses <= like every other state update.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state_q   <= RUN;
      pc_q      <= '0;
      instr_q   <= '0;
      pc_next_q <= '0;
      valid_q   <= 1'b0;
      count_q   <= '0;
    end else begin
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      pc_next_q <= pc_next_d;
      valid_q   <= valid_d;
      count_q   <= count_d;
      if (i_enable) begin
        case (state_q)
          RUN:     if (halt_entry) state_q <= HALTED;
          HALTED:  if (redirect)   state_q <= RUN;
          default: state_q <= RUN;
        endcase
      end
    end
  end

  assign o_imem_addr   = pc_q;
  assign o_instr       = instr_q;
  assign o_pc_next     = pc_next_q;
  assign o_valid       = valid_q;
  assign o_halt        = (state_q == HALTED);
  assign o_cycle_count = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed per-cycle vectors push expected
// IF/ID state; a monitor pops and compares after each rising edge.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n, en, haz, br, jmp;
  logic [31:0] bt, jt;
  logic [31:0] addr, addr_s, data, data_s;
  logic [31:0] instr, instr_s, pc_next, pc_next_s;
  logic        valid, valid_s, halt, halt_s;
  logic [31:0] cnt;
  logic [3:0]  cnt_s;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc_next;
    bit          chk_pn;
    logic        valid;
    logic        halt;
    logic [31:0] cnt;
    logic [3:0]  cnt_small;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [31:0] model_cnt  = 0;
  logic        prev_halt  = 1'b0;

  always #5 clk = ~clk;

  function automatic logic [31:0] imem(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h2001_0005;
      32'h0000_0004: return 32'h2002_0007;
      32'h0000_0008: return 32'h2003_0009;
      32'h0000_000C: return 32'h2004_000B;
      32'h0000_0010: return 32'hFC00_0000;
      32'h0000_0020: return 32'h2005_0001;
      32'h0000_0024: return 32'h2006_0002;
      32'h0000_0040: return 32'h0000_0020;
      32'h0000_0044: return 32'h0000_0022;
      32'hFFFF_FFFC: return 32'h3C01_ABCD;
      default:       return 32'h0000_0000;
    endcase
  endfunction

  assign data   = imem(addr);
  assign data_s = imem(addr_s);

  fetch_stage dut (
    .i_clock(clk), .i_reset(rst_n), .i_enable(en), .i_hazard(haz),
    .i_branch_taken(br), .i_branch_target(bt), .i_jump(jmp), .i_jump_target(jt),
    .o_imem_addr(addr), .i_imem_data(data), .o_instr(instr), .o_pc_next(pc_next),
    .o_valid(valid), .o_halt(halt), .o_cycle_count(cnt)
  );

  fetch_stage #(.NB_COUNT(4)) dut_small (
    .i_clock(clk), .i_reset(rst_n), .i_enable(en), .i_hazard(haz),
    .i_branch_taken(br), .i_branch_target(bt), .i_jump(jmp), .i_jump_target(jt),
    .o_imem_addr(addr_s), .i_imem_data(data_s), .o_instr(instr_s), .o_pc_next(pc_next_s),
    .o_valid(valid_s), .o_halt(halt_s), .o_cycle_count(cnt_s)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: one expected entry per clock edge once stimulus has started.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        check({e.name, ".pc"},    addr,  e.pc);
        check({e.name, ".instr"}, instr, e.instr);
        if (e.chk_pn) check({e.name, ".pc_next"}, pc_next, e.pc_next);
        check({e.name, ".valid"}, 32'(valid), 32'(e.valid));
        check({e.name, ".halt"},  32'(halt),  32'(e.halt));
        check({e.name, ".count"}, cnt, e.cnt);
        check({e.name, ".count_sat4"}, 32'(cnt_s), 32'(e.cnt_small));
        check({e.name, ".pc_small"}, addr_s, e.pc);
      end
    end
  end

  task automatic set_in(input logic r, input logic e, input logic h,
                        input logic b, input logic [31:0] bta,
                        input logic j, input logic [31:0] jta);
    @(negedge clk);
    rst_n = r; en = e; haz = h; br = b; bt = bta; jmp = j; jt = jta;
  endtask

  task automatic expect_after(input string name, input logic [31:0] pc,
                              input logic [31:0] ins, input logic [31:0] pn,
                              input bit chk_pn, input logic v, input logic h);
    exp_t e;
    if (!rst_n)                model_cnt = 0;
    else if (en && !prev_halt) model_cnt = model_cnt + 1;
    prev_halt   = h;
    e.name      = name;
    e.pc        = pc;
    e.instr     = ins;
    e.pc_next   = pn;
    e.chk_pn    = chk_pn;
    e.valid     = v;
    e.halt      = h;
    e.cnt       = model_cnt;
    e.cnt_small = (model_cnt > 15) ? 4'hF : model_cnt[3:0];
    q.push_back(e);
  endtask

  initial begin
    int budget;
    rst_n = 1'b0; en = 1'b0; haz = 1'b0; br = 1'b0; jmp = 1'b0; bt = '0; jt = '0;
    repeat (2) @(negedge clk);

    set_in(0,1,0,0,0,0,0);           expect_after("reset",       32'h00, 32'h0,         32'h00, 1, 0, 0);
    set_in(1,1,0,0,0,0,0);           expect_after("adv0",        32'h04, 32'h2001_0005, 32'h04, 1, 1, 0);
    set_in(1,1,0,0,0,0,0);           expect_after("adv1",        32'h08, 32'h2002_0007, 32'h08, 1, 1, 0);
    set_in(1,1,1,0,0,0,0);           expect_after("stall0",      32'h08, 32'h2002_0007, 32'h08, 1, 1, 0);
    set_in(1,1,1,0,0,0,0);           expect_after("stall1",      32'h08, 32'h2002_0007, 32'h08, 1, 1, 0);
    set_in(1,1,0,0,0,0,0);           expect_after("resume",      32'h0C, 32'h2003_0009, 32'h0C, 1, 1, 0);
    set_in(1,0,1,1,32'h40,0,0);      expect_after("hold0",       32'h0C, 32'h2003_0009, 32'h0C, 1, 1, 0);
    set_in(1,0,0,0,0,1,32'h80);      expect_after("hold1",       32'h0C, 32'h2003_0009, 32'h0C, 1, 1, 0);
    set_in(1,0,0,0,0,0,0);           expect_after("hold2",       32'h0C, 32'h2003_0009, 32'h0C, 1, 1, 0);
    set_in(1,1,1,1,32'h40,1,32'h80); expect_after("br_jmp_haz",  32'h40, 32'h0,         32'h00, 1, 0, 0);
    set_in(1,1,0,0,0,0,0);           expect_after("adv40",       32'h44, 32'h0000_0020, 32'h44, 1, 1, 0);
    set_in(1,1,0,0,0,1,32'h10);      expect_after("jmp10",       32'h10, 32'h0,         32'h00, 1, 0, 0);
    set_in(1,1,0,0,0,0,0);           expect_after("halt_entry",  32'h10, 32'hFC00_0000, 32'h14, 1, 1, 1);
    set_in(1,1,1,0,0,0,0);           expect_after("halted0",     32'h10, 32'h0,         32'h00, 0, 0, 1);
    set_in(1,1,0,0,0,0,0);           expect_after("halted1",     32'h10, 32'h0,         32'h00, 0, 0, 1);
    set_in(1,0,0,0,0,0,0);           expect_after("halted_hold", 32'h10, 32'h0,         32'h00, 0, 0, 1);
    set_in(1,1,0,0,0,1,32'h20);      expect_after("halt_exit",   32'h20, 32'h0,         32'h00, 1, 0, 0);
    set_in(1,1,0,0,0,0,0);           expect_after("adv20",       32'h24, 32'h2005_0001, 32'h24, 1, 1, 0);
    set_in(1,1,0,0,0,1,32'hFFFF_FFFC); expect_after("jmp_top",   32'hFFFF_FFFC, 32'h0,  32'h00, 1, 0, 0);
    set_in(1,1,0,0,0,0,0);           expect_after("pc_wrap",     32'h00, 32'h3C01_ABCD, 32'h00, 1, 1, 0);
    set_in(1,1,0,0,0,0,0);           expect_after("adv_wrap",    32'h04, 32'h2001_0005, 32'h04, 1, 1, 0);
    set_in(1,1,0,1,32'h40,0,0);      expect_after("br40",        32'h40, 32'h0,         32'h00, 1, 0, 0);
    set_in(1,1,0,0,0,0,0);           expect_after("adv40b",      32'h44, 32'h0000_0020, 32'h44, 1, 1, 0);
    set_in(1,1,0,0,0,0,0);           expect_after("adv44",       32'h48, 32'h0000_0022, 32'h48, 1, 1, 0);
    set_in(1,1,1,0,0,0,0);           expect_after("stall48",     32'h48, 32'h0000_0022, 32'h48, 1, 1, 0);
    set_in(0,1,1,0,0,0,0);           expect_after("rst_stall",   32'h00, 32'h0,         32'h00, 1, 0, 0);
    set_in(1,1,0,0,0,0,0);           expect_after("adv_rst",     32'h04, 32'h2001_0005, 32'h04, 1, 1, 0);
    set_in(1,1,0,0,0,1,32'h10);      expect_after("jmp10b",      32'h10, 32'h0,         32'h00, 1, 0, 0);
    set_in(1,1,0,0,0,0,0);           expect_after("halt_b",      32'h10, 32'hFC00_0000, 32'h14, 1, 1, 1);
    set_in(1,1,0,0,0,0,0);           expect_after("halted_b",    32'h10, 32'h0,         32'h00, 0, 0, 1);
    set_in(0,1,0,0,0,1,32'h20);      expect_after("rst_halted",  32'h00, 32'h0,         32'h00, 1, 0, 0);
    set_in(1,1,0,0,0,0,0);           expect_after("adv_rst2",    32'h04, 32'h2001_0005, 32'h04, 1, 1, 0);

    budget = 10;
    while (q.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected entries left, required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline. Owns the PC and the IF/ID pipeline register.
- Consumes the load-use stall (o_hazard) from the hazard unit in ID.
- Consumes branch/jump redirects from the decode/execute logic.
- Detects the HALT instruction and freezes fetch, so the debug unit can read the final state.

Parameters:
- NB_ADDR, 32, PC / instruction-memory address width (byte address).
- NB_INSTR, 32, instruction width.
- NB_OPCODE, 6, opcode field width (instruction bits [NB_INSTR-1 -: NB_OPCODE]).
- HALT_OPCODE, 6'b111111, opcode that halts fetch.
- NB_COUNT, 32, cycle-counter width.

Ports:
- i_clock  in  1  system clock; all state updates on rising edge.
- i_reset  in  1  synchronous, active-low reset.
- i_enable  in  1  global run/step enable from debug unit; 0 = full hold.
- i_hazard  in  1  load-use stall from hazard unit.
- i_branch_taken  in  1  taken branch resolved downstream.
- i_branch_target  in  NB_ADDR  branch destination.
- i_jump  in  1  jump decoded in ID.
- i_jump_target  in  NB_ADDR  jump destination.
- o_imem_addr  out  NB_ADDR  instruction-memory address (= PC, combinational).
- i_imem_data  in  NB_INSTR  instruction at o_imem_addr (asynchronous read, same cycle).
- o_instr  out  NB_INSTR  IF/ID instruction.
- o_pc_next  out  NB_ADDR  IF/ID PC+4 of o_instr.
- o_valid  out  1  IF/ID holds a real instruction (0 = bubble).
- o_halt  out  1  fetch halted.
- o_cycle_count  out  NB_COUNT  enabled cycles spent in RUN.

Behaviour:
- Reset (i_reset==0 at edge) drives: PC=0, o_instr=0 (NOP), o_pc_next=0, o_valid=0, o_halt=0, o_cycle_count=0, FSM=RUN. Reset overrides every other input, including mid-halt and mid-stall.
- i_enable==0: PC, IF/ID, FSM and counter all hold, regardless of other inputs.
- FSM states: RUN, HALTED.
- RUN, with i_enable==1. Priority is redirect > stall > advance:
  - i_branch_taken: PC<=i_branch_target; IF/ID flushed (o_instr=0, o_valid=0, o_pc_next=0).
  - else i_jump: PC<=i_jump_target; IF/ID flushed.
  - else i_hazard: PC and IF/ID hold unchanged.
  - else: PC<=PC+4; o_instr<=i_imem_data; o_pc_next<=PC+4; o_valid<=1.
- Simultaneous branch and jump: branch wins, since it comes from the older instruction.
- Hazard with any redirect: the redirect wins. The stalled ID instruction is being flushed anyway.
- Halt entry:
  - Occurs on the advance case when i_imem_data opcode == HALT_OPCODE.
  - The HALT is loaded into IF/ID with o_valid=1 so it propagates down the pipeline.
  - PC does NOT advance; it keeps pointing at the HALT.
  - FSM -> HALTED; o_halt=1 from the next cycle.
- HALTED, with i_enable==1:
  - PC holds; IF/ID loads bubbles (o_instr=0, o_valid=0) so the pipeline drains.
  - i_hazard is ignored.
  - Cycle counter holds.
- HALTED exit via redirect: i_branch_taken or i_jump means the HALT was speculative. Take the redirect as in RUN, flush IF/ID, FSM -> RUN, o_halt=0 next cycle.
- HALTED exit otherwise: leaves only via reset.
- Arithmetic:
  - PC+4 is computed modulo 2^NB_ADDR, so 0xFFFFFFFC advances to 0x00000000.
  - Targets are used as given; no alignment check.
- Cycle counter: +1 on each enabled cycle in RUN, stalls and flushes included. Saturates at all-ones (no wrap).
- Latency: an instruction addressed in cycle N appears on o_instr after edge N (one register stage).

Test Plan:
- Reset then i_enable=1; imem returns 0x20010005 @0 and 0x20020007 @4 -> o_imem_addr 0,4,8; o_instr 0x20010005/o_pc_next 4, then 0x20020007/o_pc_next 8; o_valid=1; o_cycle_count=2 after two cycles.
- i_hazard=1 for 2 cycles at PC=8 -> o_imem_addr stays 8; o_instr/o_pc_next unchanged; counter still increments; normal advance resumes when i_hazard drops.
- i_branch_taken=1, i_branch_target=0x40, i_jump=1, i_jump_target=0x80, i_hazard=1 in the same cycle -> PC=0x40, o_instr=0, o_valid=0.
- imem returns 0xFC000000 @0x10 -> o_instr=0xFC000000, o_valid=1; then o_halt=1, PC frozen at 0x10, following cycles o_valid=0, counter frozen.
- In HALTED, assert i_jump with target 0x20 -> o_halt=0, PC=0x20, fetch resumes.
- Other boundaries:
  - PC=0xFFFFFFFC advances to 0.
  - i_enable=0 for 3 cycles holds every output.
  - Counter preloaded near max saturates at 0xFFFFFFFF.
  - i_reset=0 mid-stall or while halted returns all outputs to reset values next edge.
